// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD conversion path.
//   state_t      : converter FSM encoding (IDLE / SHIFT)
//   BCD_W        : width of one BCD digit field
//   MAX_DISP_DEF : largest value the seven-segment display can show
//   CNT_W        : width of the shift iteration counter
package bcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int BCD_W        = 4;
  localparam int MAX_DISP_DEF = 99;
  localparam int CNT_W        = 3;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD field holding 5 or more so
// that the following left shift carries correctly into the next decade.
//   din  : 4-bit field before correction
//   dout : 4-bit field after correction
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Sits downstream of the 7-bit counter and feeds the seven-segment driver.
//   CLK      : system clock, rising edge
//   RST      : synchronous active-high reset
//   bin_in   : binary value to convert (sampled only when accepted in IDLE)
//   in_valid : conversion request, ignored while busy
//   busy     : high while a conversion is in progress
//   done     : one-cycle pulse when hund/tens/ones/overflow update
//   hund     : hundreds digit (0 or 1)
//   tens     : tens digit, BCD
//   ones     : ones digit, BCD
//   overflow : converted value exceeded MAX_DISP (registered with digits)
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int MAX_DISP = MAX_DISP_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] bin_in,
  input  logic             in_valid,
  output logic             busy,
  output logic             done,
  output logic             hund,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             overflow
);

  // Working register layout, MSB to LSB:
  //   {hund scratch, tens, ones, remaining binary bits}
  localparam int WORK_W  = 3*BCD_W + WIDTH;
  localparam int ONES_LO = WIDTH;
  localparam int TENS_LO = WIDTH + BCD_W;
  localparam int HUND_LO = WIDTH + 2*BCD_W;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_DISP);

  state_t            state;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] corrected;
  logic [WORK_W-1:0] shifted;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_pend;
  logic [BCD_W-1:0]  hund_adj;
  logic [BCD_W-1:0]  tens_adj;
  logic [BCD_W-1:0]  ones_adj;

  bcd_add3 u_add3_hund (.din(work[HUND_LO +: BCD_W]), .dout(hund_adj));
  bcd_add3 u_add3_tens (.din(work[TENS_LO +: BCD_W]), .dout(tens_adj));
  bcd_add3 u_add3_ones (.din(work[ONES_LO +: BCD_W]), .dout(ones_adj));

  // Correction is applied before the shift within the same cycle; the top
  // bit of the hundreds scratch field falls off, which is harmless because
  // a 7-bit input never produces more than 1 hundred.
  assign corrected = {hund_adj, tens_adj, ones_adj, work[WIDTH-1:0]};
  assign shifted   = corrected << 1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      work     <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hund     <= 1'b0;
      tens     <= '0;
      ones     <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work     <= {{(3*BCD_W){1'b0}}, bin_in};
            cnt      <= CNT_W'(WIDTH);
            // Overflow depends only on the latched input, so resolve it now
            // and hold it until the digits are published.
            ovf_pend <= (bin_in > MAX_V);
            busy     <= 1'b1;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work <= shifted;
          cnt  <= cnt - CNT_W'(1);
          // Last iteration: publish the final shifted fields directly.
          if (cnt == CNT_W'(1)) begin
            hund     <= shifted[HUND_LO];
            tens     <= shifted[TENS_LO +: BCD_W];
            ones     <= shifted[ONES_LO +: BCD_W];
            overflow <= ovf_pend;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  typedef struct {
    int       v;
    logic     h;
    logic [3:0] t;
    logic [3:0] o;
    logic     ovf;
    int       cyc;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic [6:0] bin_in;
  logic       in_valid;
  logic       busy;
  logic       done;
  logic       hund;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       overflow;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];

  bin2bcd_seq #(.WIDTH(7), .MAX_DISP(99)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bin_in   (bin_in),
    .in_valid (in_valid),
    .busy     (busy),
    .done     (done),
    .hund     (hund),
    .tens     (tens),
    .ones     (ones),
    .overflow (overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input int v, input int done_cyc);
    exp_t e;
    e.v   = v;
    e.h   = (v / 100) != 0;
    e.t   = 4'((v / 10) % 10);
    e.o   = 4'(v % 10);
    e.ovf = (v > 99);
    e.cyc = done_cyc;
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("done_without_request", done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("hund_v%0d", e.v), hund, e.h);
        chk($sformatf("tens_v%0d", e.v), tens, e.t);
        chk($sformatf("ones_v%0d", e.v), ones, e.o);
        chk($sformatf("ovf_v%0d", e.v), overflow, e.ovf);
        chk($sformatf("latency_v%0d", e.v), cyc, e.cyc);
      end
    end
  end

  // Drive a one-cycle request; returns at the negedge following the
  // accepting edge, so cyc then equals the accept edge number.
  task automatic send(input int v, input bit expect_result);
    bin_in   = 7'(v);
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    if (expect_result) sb.push_back(make_exp(v, cyc + 7));
  endtask

  int cnt_model;
  int first_done;

  initial begin
    RST      = 1'b1;
    bin_in   = '0;
    in_valid = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hund", hund, 1'b0);
    chk("rst_tens", tens, 4'd0);
    chk("rst_ones", ones, 4'd0);
    chk("rst_ovf", overflow, 1'b0);
    RST = 1'b0;
    @(negedge CLK);

    // 1: zero, busy for exactly 7 cycles then a done pulse
    send(0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("t1_busy_high", busy, 1'b1);
      chk("t1_done_low", done, 1'b0);
      @(negedge CLK);
    end
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_done_pulse", done, 1'b1);
    @(negedge CLK);
    chk("t1_done_drop", done, 1'b0);

    // 2: 99, upper display boundary
    send(99, 1'b1);
    repeat (7) @(negedge CLK);
    chk("t2_done", done, 1'b1);
    repeat (2) @(negedge CLK);

    // 3: 127 then 100 back-to-back, second request in the done cycle
    send(127, 1'b1);
    repeat (7) @(negedge CLK);
    chk("t3_first_done", done, 1'b1);
    first_done = cyc;
    send(100, 1'b1);
    chk("t3_busy_again", busy, 1'b1);
    chk("t3_done_dropped", done, 1'b0);
    repeat (7) @(negedge CLK);
    chk("t3_second_done", done, 1'b1);
    chk("t3_done_spacing", cyc - first_done, 8);
    repeat (2) @(negedge CLK);

    // 4: input changes and in_valid stays high while busy
    send(42, 1'b1);
    bin_in   = 7'd57;
    in_valid = 1'b1;
    repeat (6) @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("t4_done", done, 1'b1);
    repeat (20) @(negedge CLK);
    chk("t4_idle", busy, 1'b0);
    chk("t4_sb_drained", sb.size(), 0);

    // 5: reset mid-conversion aborts without a done
    send(85, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("t5_busy_cleared", busy, 1'b0);
    chk("t5_hund_cleared", hund, 1'b0);
    chk("t5_tens_cleared", tens, 4'd0);
    chk("t5_ones_cleared", ones, 4'd0);
    chk("t5_no_done", done, 1'b0);
    repeat (10) @(negedge CLK);
    chk("t5_still_idle", busy, 1'b0);
    send(85, 1'b1);
    repeat (9) @(negedge CLK);

    // 6: sweep the counter's full range, back-to-back requests
    cnt_model = 0;
    for (int k = 0; k < 128; k++) begin
      send(cnt_model, 1'b1);
      repeat (7) @(negedge CLK);
      cnt_model = (cnt_model + 1) % 128;
    end
    repeat (10) @(negedge CLK);
    chk("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
